// File: rtl/key_tone_player.sv
// Key-triggered square-wave tone generator: the lowest newly pressed key selects a half-period,
// and the tone runs for a fixed duration (one-shot) or while its key stays down (hold).
module key_tone_player #(
  parameter int                            NUM_KEYS     = 4,
  parameter int                            IDX_W        = 2,
  parameter int                            SPK_W        = 8,
  parameter int                            CNT_W        = 18,
  parameter logic [NUM_KEYS*CNT_W-1:0]     HALF_PERIODS = {18'd138504, 18'd130548, 18'd123456, 18'd116279},
  parameter int                            DUR_W        = 27,
  parameter int                            DURATION     = 80000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                mode,
  output logic [SPK_W-1:0]    speaker,
  output logic                busy,
  output logic [IDX_W-1:0]    note
);

  localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(DURATION - 1);

  logic [NUM_KEYS-1:0] keys_q;
  logic                spk_q, spk_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    note_q, note_d;
  logic [CNT_W-1:0]    hc_q, hc_d;
  logic [DUR_W-1:0]    dc_q, dc_d;

  logic [NUM_KEYS-1:0] rise_s;
  logic                trig_s;
  logic [IDX_W-1:0]    trig_idx_s;
  logic                held_s;

  function automatic logic [CNT_W-1:0] half_period(input logic [IDX_W-1:0] idx);
    logic [CNT_W-1:0] hp;
    hp = HALF_PERIODS[CNT_W-1:0];
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (idx == IDX_W'(i)) hp = HALF_PERIODS[i*CNT_W +: CNT_W];
    end
    return hp;
  endfunction

  // Scanning from the top down leaves the lowest set index as the winner.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic key_level(input logic [NUM_KEYS-1:0] vec, input logic [IDX_W-1:0] idx);
    logic lvl;
    lvl = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (idx == IDX_W'(i)) lvl = vec[i];
    end
    return lvl;
  endfunction

  assign rise_s     = keys & ~keys_q;
  assign trig_s     = |rise_s;
  assign trig_idx_s = lowest_idx(rise_s);
  assign held_s     = key_level(keys, note_q);

  // Next-state: trigger first, then toggle, then termination (which overrides the toggle).
  always_comb begin
    spk_d  = spk_q;
    busy_d = busy_q;
    note_d = note_q;
    hc_d   = hc_q;
    dc_d   = dc_q;
    if (trig_s) begin
      note_d = trig_idx_s;
      busy_d = 1'b1;
      spk_d  = 1'b0;
      hc_d   = half_period(trig_idx_s) - CNT_W'(1);
      dc_d   = DUR_LOAD;
    end else if (busy_q) begin
      if (hc_q == '0) begin
        spk_d = ~spk_q;
        hc_d  = half_period(note_q) - CNT_W'(1);
      end else begin
        hc_d  = hc_q - CNT_W'(1);
      end
      if (!mode) begin
        if (dc_q == '0) begin
          busy_d = 1'b0;
          spk_d  = 1'b0;
        end else begin
          dc_d   = dc_q - DUR_W'(1);
        end
      end else begin
        if (!held_s) begin
          busy_d = 1'b0;
          spk_d  = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
    end else begin
      spk_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= '0;
      spk_q  <= 1'b0;
      busy_q <= 1'b0;
      note_q <= '0;
      hc_q   <= '0;
      dc_q   <= '0;
    end else begin
      keys_q <= keys;
      spk_q  <= spk_d;
      busy_q <= busy_d;
      note_q <= note_d;
      hc_q   <= hc_d;
      dc_q   <= dc_d;
    end
  end

  assign speaker = {SPK_W{spk_q}};
  assign busy    = busy_q;
  assign note    = note_q;

endmodule

// File: tb/tb_key_tone_player.sv
// Self-checking bench for key_tone_player: directed scenarios plus a randomized run
// against an age-based behavioural model of the tone player.
module tb_key_tone_player;

  localparam int DUR = 20;

  logic       clk;
  logic       rst;
  logic [3:0] keys;
  logic       mode;
  logic [7:0] speaker;
  logic       busy;
  logic [1:0] note;

  int n_tests;
  int n_fail;

  int hp [4] = '{2, 3, 4, 5};

  // Model: age counts edges since the trigger; os counts one-shot edges consumed.
  logic       m_busy;
  logic [1:0] m_note;
  int         m_age;
  int         m_os;
  logic [3:0] m_prev;

  key_tone_player #(
    .NUM_KEYS    (4),
    .IDX_W       (2),
    .SPK_W       (8),
    .CNT_W       (4),
    .HALF_PERIODS({4'd5, 4'd4, 4'd3, 4'd2}),
    .DUR_W       (6),
    .DURATION    (DUR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .keys   (keys),
    .mode   (mode),
    .speaker(speaker),
    .busy   (busy),
    .note   (note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic [3:0] k, input logic m, input logic r);
    logic [3:0] rise;
    rise = k & ~m_prev;
    if (r) begin
      m_busy = 1'b0; m_note = 2'd0; m_age = 0; m_os = 0; m_prev = 4'd0;
    end else begin
      m_prev = k;
      if (rise != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (rise[i]) m_note = 2'(i);
        m_busy = 1'b1; m_age = 0; m_os = 0;
      end else if (m_busy) begin
        m_age++;
        if (m == 1'b0) begin
          if (m_os == DUR - 1) m_busy = 1'b0;
          else m_os++;
        end else if (k[m_note] == 1'b0) begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [7:0] model_spk();
    if (!m_busy) return 8'h00;
    return (((m_age / hp[m_note]) % 2) == 1) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] sq(input int age, input int h);
    return (((age / h) % 2) == 1) ? 8'hFF : 8'h00;
  endfunction

  // Apply inputs for one edge, advance the model, and leave time 1 unit after the edge.
  task automatic cycle(input logic [3:0] k, input logic m, input logic r);
    keys = k; mode = m; rst = r;
    @(posedge clk);
    model_edge(k, m, r);
    #1;
  endtask

  task automatic test_reset();
    cycle(4'd0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b1);
    n_tests++;
    if ({speaker, busy, note} !== {8'h00, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: got spk=%h busy=%b note=%0d expected 00/0/0", speaker, busy, note);
    end
    cycle(4'd0, 1'b0, 1'b0);
    n_tests++;
    if ({speaker, busy} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got spk=%h busy=%b expected 00/0", speaker, busy);
    end
  endtask

  task automatic test_oneshot();
    int busy_cnt;
    cycle(4'b0010, 1'b0, 1'b0);
    n_tests++;
    if ({speaker, busy, note} !== {8'h00, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL oneshot_start: got spk=%h busy=%b note=%0d expected 00/1/1", speaker, busy, note);
    end
    busy_cnt = 1;
    for (int i = 1; i <= 22; i++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      if (busy) busy_cnt++;
      n_tests++;
      if ({speaker, busy} !== {(i < DUR) ? sq(i, 3) : 8'h00, i < DUR}) begin
        n_fail++;
        $display("FAIL oneshot_wave age=%0d: got spk=%h busy=%b expected spk=%h busy=%b",
                 i, speaker, busy, (i < DUR) ? sq(i, 3) : 8'h00, i < DUR);
      end
    end
    n_tests++;
    if (busy_cnt !== DUR) begin
      n_fail++;
      $display("FAIL oneshot_length: got %0d busy cycles expected %0d", busy_cnt, DUR);
    end
  endtask

  task automatic test_simultaneous();
    cycle(4'b1100, 1'b0, 1'b0);
    n_tests++;
    if ({busy, note} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL simul_note: got busy=%b note=%0d expected 1/2", busy, note);
    end
    for (int i = 1; i <= 10; i++) begin
      cycle(4'b1000, 1'b0, 1'b0);
      n_tests++;
      if ({speaker, busy, note} !== {sq(i, 4), 1'b1, 2'd2}) begin
        n_fail++;
        $display("FAIL simul_wave age=%0d: got spk=%h busy=%b note=%0d expected %h/1/2",
                 i, speaker, busy, note, sq(i, 4));
      end
    end
    for (int i = 0; i < 12; i++) cycle(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_retrigger();
    cycle(4'b0001, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    n_tests++;
    if ({speaker, busy, note} !== {8'h00, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL retrig_phase: got spk=%h busy=%b note=%0d expected 00/1/0", speaker, busy, note);
    end
    for (int j = 1; j <= 21; j++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      n_tests++;
      if ({speaker, busy} !== {(j < DUR) ? sq(j, 2) : 8'h00, j < DUR}) begin
        n_fail++;
        $display("FAIL retrig_wave t=E0+%0d: got spk=%h busy=%b expected spk=%h busy=%b",
                 j + 10, speaker, busy, (j < DUR) ? sq(j, 2) : 8'h00, j < DUR);
      end
    end
  endtask

  task automatic test_hold();
    int busy_cnt;
    busy_cnt = 0;
    for (int j = 0; j < 50; j++) begin
      cycle(4'b1000, 1'b1, 1'b0);
      if (busy) busy_cnt++;
      n_tests++;
      if ({speaker, busy, note} !== {sq(j, 5), 1'b1, 2'd3}) begin
        n_fail++;
        $display("FAIL hold_wave age=%0d: got spk=%h busy=%b note=%0d expected %h/1/3",
                 j, speaker, busy, note, sq(j, 5));
      end
    end
    cycle(4'b0000, 1'b1, 1'b0);
    n_tests++;
    if ({speaker, busy, busy_cnt} !== {8'h00, 1'b0, 32'd50}) begin
      n_fail++;
      $display("FAIL hold_release: got spk=%h busy=%b cnt=%0d expected 00/0/50", speaker, busy, busy_cnt);
    end
  endtask

  task automatic test_hold_switch();
    for (int j = 0; j < 4; j++) cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0101, 1'b1, 1'b0);
    n_tests++;
    if ({speaker, busy, note} !== {8'h00, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL hold_switch: got spk=%h busy=%b note=%0d expected 00/1/2", speaker, busy, note);
    end
    for (int j = 1; j <= 9; j++) begin
      cycle(4'b0100, 1'b1, 1'b0);
      n_tests++;
      if ({speaker, busy, note} !== {sq(j, 4), 1'b1, 2'd2}) begin
        n_fail++;
        $display("FAIL hold_switch_wave age=%0d: got spk=%h busy=%b note=%0d expected %h/1/2",
                 j, speaker, busy, note, sq(j, 4));
      end
    end
    cycle(4'b0000, 1'b1, 1'b0);
    n_tests++;
    if ({speaker, busy} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_switch_end: got spk=%h busy=%b expected 00/0", speaker, busy);
    end
  endtask

  task automatic test_rst_midtone();
    for (int j = 0; j < 7; j++) cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b1);
    n_tests++;
    if ({speaker, busy, note} !== {8'h00, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: got spk=%h busy=%b note=%0d expected 00/0/0", speaker, busy, note);
    end
    cycle(4'b0010, 1'b0, 1'b0);
    n_tests++;
    if ({speaker, busy, note} !== {8'h00, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL rst_held_key: got spk=%h busy=%b note=%0d expected 00/1/1", speaker, busy, note);
    end
    for (int j = 0; j < 22; j++) cycle(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] k;
    logic       m;
    logic       r;
    int         shown;
    k = 4'd0; m = 1'b0; shown = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) m = ~m;
      r = ($urandom_range(0, 299) == 0);
      cycle(k, m, r);
      n_tests++;
      if ({speaker, busy, note} !== {model_spk(), m_busy, m_note}) begin
        n_fail++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cyc=%0d: got spk=%h busy=%b note=%0d expected spk=%h busy=%b note=%0d",
                   c, speaker, busy, note, model_spk(), m_busy, m_note);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_busy = 1'b0; m_note = 2'd0; m_age = 0; m_os = 0; m_prev = 4'd0;
    rst = 1'b1; keys = 4'd0; mode = 1'b0;
    test_reset();
    test_oneshot();
    test_simultaneous();
    test_retrigger();
    test_hold();
    test_hold_switch();
    test_rst_midtone();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
